// File: rtl/regfile_writeback_queue.sv
// Write-back queue feeding the register file write port (RW/BusW/RegWr), one retire per cycle.
// Optional pending-write lookup (Q_RA/Q_Hit/Q_Data) enabled by defining PENDING_FWD_EN.
module regfile_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   M_Valid,
    input  logic [ADDR_W-1:0]      M_RW,
    input  logic [DATA_W-1:0]      M_BusW,
    output logic                   M_Ready,
    input  logic                   A_Valid,
    input  logic [ADDR_W-1:0]      A_RW,
    input  logic [DATA_W-1:0]      A_BusW,
    output logic                   A_Ready,
    output logic [ADDR_W-1:0]      RW,
    output logic [DATA_W-1:0]      BusW,
    output logic                   RegWr,
    output logic [$clog2(DEPTH):0] Count,
    output logic                   Empty,
    output logic                   Full,
    input  logic [ADDR_W-1:0]      Q_RA,
    output logic                   Q_Hit,
    output logic [DATA_W-1:0]      Q_Data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] ent_rw_q   [DEPTH];
    logic [ADDR_W-1:0] ent_rw_d   [DEPTH];
    logic [DATA_W-1:0] ent_data_q [DEPTH];
    logic [DATA_W-1:0] ent_data_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, a_slot;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              regwr_q, regwr_d;
    logic [ADDR_W-1:0] rw_q, rw_d;
    logic [DATA_W-1:0] busw_q, busw_d;
    logic              m_ready, a_ready, m_push, a_push, pop;

    always_comb begin
        m_ready = (count_q < CNT_W'(DEPTH));
        m_push  = M_Valid && m_ready && (M_RW != '0);
        // A needs a second free slot only when M actually occupies one this edge
        a_ready = m_push ? (count_q < CNT_W'(DEPTH - 1)) : m_ready;
        a_push  = A_Valid && a_ready && (A_RW != '0);
        pop     = (count_q != '0);

        ent_rw_d   = ent_rw_q;
        ent_data_d = ent_data_q;
        head_d     = head_q;
        regwr_d    = 1'b0;
        rw_d       = rw_q;
        busw_d     = busw_q;

        a_slot = m_push ? (tail_q + PTR_W'(1)) : tail_q;
        if (m_push) begin
            ent_rw_d[tail_q]   = M_RW;
            ent_data_d[tail_q] = M_BusW;
        end
        if (a_push) begin
            ent_rw_d[a_slot]   = A_RW;
            ent_data_d[a_slot] = A_BusW;
        end
        tail_d = tail_q + PTR_W'(m_push) + PTR_W'(a_push);

        if (pop) begin
            regwr_d = 1'b1;
            rw_d    = ent_rw_q[head_q];
            busw_d  = ent_data_q[head_q];
            head_d  = head_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(m_push) + CNT_W'(a_push) - CNT_W'(pop);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_rw_q[i]   <= '0;
                ent_data_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            regwr_q <= 1'b0;
            rw_q    <= '0;
            busw_q  <= '0;
        end else begin
            ent_rw_q   <= ent_rw_d;
            ent_data_q <= ent_data_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            regwr_q    <= regwr_d;
            rw_q       <= rw_d;
            busw_q     <= busw_d;
        end
    end

    assign M_Ready = m_ready;
    assign A_Ready = a_ready;
    assign RW      = rw_q;
    assign BusW    = busw_q;
    assign RegWr   = regwr_q;
    assign Count   = count_q;
    assign Empty   = (count_q == '0);
    assign Full    = (count_q == CNT_W'(DEPTH));

`ifdef PENDING_FWD_EN
    // Scan oldest to youngest so the youngest valid match wins; output regs rank below all entries
    always_comb begin
        Q_Hit  = 1'b0;
        Q_Data = '0;
        if (regwr_q && (rw_q == Q_RA)) begin
            Q_Hit  = 1'b1;
            Q_Data = busw_q;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) && (ent_rw_q[head_q + PTR_W'(i)] == Q_RA)) begin
                Q_Hit  = 1'b1;
                Q_Data = ent_data_q[head_q + PTR_W'(i)];
            end
        end
        if (Q_RA == '0) begin
            Q_Hit  = 1'b0;
            Q_Data = '0;
        end
    end
`else
    logic unused_q_ra;
    assign unused_q_ra = ^Q_RA;
    assign Q_Hit       = 1'b0;
    assign Q_Data      = '0;
`endif
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue: scoreboard of accepted writes checked at retire.
// Forwarding expectations follow PENDING_FWD_EN when defined.
module tb_regfile_writeback_queue;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              Clk, Reset_n;
    logic              M_Valid, A_Valid, M_Ready, A_Ready;
    logic [ADDR_W-1:0] M_RW, A_RW, RW, Q_RA;
    logic [DATA_W-1:0] M_BusW, A_BusW, BusW, Q_Data;
    logic              RegWr, Empty, Full, Q_Hit;
    logic [$clog2(DEPTH):0] Count;

    typedef struct {
        logic [ADDR_W-1:0] rw;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  model_cnt = 0;

    regfile_writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .M_Valid(M_Valid), .M_RW(M_RW), .M_BusW(M_BusW), .M_Ready(M_Ready),
        .A_Valid(A_Valid), .A_RW(A_RW), .A_BusW(A_BusW), .A_Ready(A_Ready),
        .RW(RW), .BusW(BusW), .RegWr(RegWr),
        .Count(Count), .Empty(Empty), .Full(Full),
        .Q_RA(Q_RA), .Q_Hit(Q_Hit), .Q_Data(Q_Data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (Reset_n === 1'b1 && RegWr === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_regwr", 32'(RegWr), 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wb_rw", 32'(RW), 32'(e.rw));
                chk("wb_data", BusW, e.data);
            end
        end
    end

    task automatic step(input logic mv, input logic [ADDR_W-1:0] mrw, input logic [DATA_W-1:0] md,
                        input logic av, input logic [ADDR_W-1:0] arw, input logic [DATA_W-1:0] ad);
        logic em, ea, mp, ap;
        wr_t  e;
        @(negedge Clk);
        M_Valid = mv; M_RW = mrw; M_BusW = md;
        A_Valid = av; A_RW = arw; A_BusW = ad;
        #1;
        chk("count", 32'(Count), 32'(model_cnt));
        chk("empty", 32'(Empty), 32'(model_cnt == 0));
        chk("full", 32'(Full), 32'(model_cnt == DEPTH));
        em = (model_cnt < DEPTH);
        mp = mv && em && (mrw != '0);
        ea = ((DEPTH - model_cnt) >= (1 + int'(mp)));
        ap = av && ea && (arw != '0);
        chk("m_ready", 32'(M_Ready), 32'(em));
        chk("a_ready", 32'(A_Ready), 32'(ea));
        if (mp) begin e.rw = mrw; e.data = md; sb.push_back(e); end
        if (ap) begin e.rw = arw; e.data = ad; sb.push_back(e); end
        model_cnt = model_cnt + int'(mp) + int'(ap) - ((model_cnt > 0) ? 1 : 0);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic fwd_chk(input string tag, input logic eh, input logic [DATA_W-1:0] ed);
`ifdef PENDING_FWD_EN
        chk({tag, "_hit"}, 32'(Q_Hit), 32'(eh));
        chk({tag, "_data"}, Q_Data, ed);
`else
        chk({tag, "_hit"}, 32'(Q_Hit), 32'd0);
        chk({tag, "_data"}, Q_Data, 32'd0);
`endif
    endtask

    initial begin
        Reset_n = 1'b0;
        M_Valid = 1'b0; M_RW = '0; M_BusW = '0;
        A_Valid = 1'b0; A_RW = '0; A_BusW = '0;
        Q_RA = '0;
        #12;
        chk("rst_regwr", 32'(RegWr), 32'd0);
        chk("rst_rw", 32'(RW), 32'd0);
        chk("rst_busw", BusW, 32'd0);
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_empty", 32'(Empty), 32'd1);
        #1 Reset_n = 1'b1;

        // single M write, two-edge latency, one RegWr cycle
        step(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, '0, '0);
        idle();
        chk("t1_regwr_early", 32'(RegWr), 32'd0);
        idle();
        chk("t1_regwr", 32'(RegWr), 32'd1);
        chk("t1_rw", 32'(RW), 32'd3);
        chk("t1_busw", BusW, 32'hDEADBEEF);
        idle();
        chk("t1_regwr_off", 32'(RegWr), 32'd0);

        // same-edge M and A
        step(1'b1, 5'd4, 32'h44, 1'b1, 5'd5, 32'h55);
        repeat (3) idle();

        // R0 request accepted but dropped
        step(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234);
        repeat (3) idle();

        // two pending writes to R7
        Q_RA = 5'd7;
        fwd_chk("t5_idle", 1'b0, '0);
        step(1'b1, 5'd7, 32'd1, 1'b0, '0, '0);
        step(1'b1, 5'd7, 32'd2, 1'b0, '0, '0);
        fwd_chk("t5_one", 1'b1, 32'd1);
        idle();
        fwd_chk("t5_young", 1'b1, 32'd2);
        Q_RA = 5'd0;
        #1;
        fwd_chk("t5_r0", 1'b0, '0);
        Q_RA = 5'd7;
        idle();
        fwd_chk("t5_outreg", 1'b1, 32'd2);
        idle();
        fwd_chk("t5_retired", 1'b0, '0);
        Q_RA = 5'd0;
        idle();

        // saturate both request ports
        for (int i = 0; i < 10; i++)
            step(1'b1, 5'(8 + i), $urandom, 1'b1, 5'(18 + i), $urandom);

        // async reset with entries pending
        @(negedge Clk);
        M_Valid = 1'b0; A_Valid = 1'b0;
        #1;
        chk("t6_count_pre", 32'(Count), 32'(model_cnt));
        #2 Reset_n = 1'b0;
        #1;
        chk("t6_regwr", 32'(RegWr), 32'd0);
        chk("t6_count", 32'(Count), 32'd0);
        chk("t6_empty", 32'(Empty), 32'd1);
        sb.delete();
        model_cnt = 0;
        @(negedge Clk);
        #1 Reset_n = 1'b1;
        repeat (6) idle();

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge Clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
